fp_operand_sequencer: RTL and testbench
=======================================

// Module: fp_operand_sequencer
// PURPOSE
//  Issue-side controller that time-multiplexes a single shared FP decoder across the up-to-3 operands of an
//  FPU op (ADD/MUL/FMA, FP32 or FP64). Accepts one op per valid/ready handshake and steps A, B, C through the
//  decoder on successive cycles. Registers decoded fields into an operand bundle and pre-computes NaN/invalid
//  special-case flags. Presents the bundle to the execute stage with valid/ready.
// PARAMETERS
//  TAG_W        4  width of the op tag carried unchanged from input to output
//  SKIP_UNUSED  1  1: skip the C decode cycle for ADD/MUL; 0: always decode C (fixed latency)
// PORTS
//  clk          in   1    clock, rising edge
//  rst_n        in   1    asynchronous active-low reset
//  in_valid     in   1    op request valid
//  in_ready     out  1    sequencer can accept an op (high only in IDLE)
//  in_op        in   2    00 ADD (A+B), 01 MUL (A*B), 10 FMA (A*B+C), 11 reserved (treated as ADD)
//  in_dp        in   1    1 = FP64, 0 = FP32 (operand in bits [31:0])
//  in_tag       in   TAG_W  op tag
//  in_a/in_b/in_c in 64   raw operands
//  dec_fp_in    out  64   to shared decoder: operand under decode
//  dec_is_dp    out  1    to shared decoder: precision of the latched op
//  dec_sign     in   1    from decoder
//  dec_exp      in   11   from decoder: biased exponent
//  dec_mant     in   53   from decoder: 1.F / 0.F significand
//  dec_is_zero/inf/nan/den  in 1 each   decoder classification
//  out_valid    out  1    bundle valid
//  out_ready    in   1    execute stage accepts bundle
//  out_op/out_dp/out_tag  out 2/1/TAG_W   latched op fields
//  out_sign     out  3    {C,B,A}
//  out_exp      out  33   {C,B,A}, A in [10:0]
//  out_mant     out  159  {C,B,A}, A in [52:0]
//  out_class    out  12   per operand {den,nan,inf,zero}, A in [3:0]
//  out_any_nan  out  1    any operand used by the op is NaN
//  out_invalid  out  1    IEEE invalid from inf/zero combos; forced 0 when out_any_nan
// BEHAVIOUR
//  - Reset (async on rst_n=0): state=IDLE, all out_* and bundle regs 0, dec_fp_in=0, dec_is_dp=0; in_ready=1 once
//    rst_n deasserts. Reset mid-op abandons the op silently; no partial bundle is ever presented.
//  - FSM: IDLE -> DEC_A -> DEC_B -> {DEC_C | DONE}; DEC_C -> DONE; DONE -> IDLE on out_valid&&out_ready.
//  - IDLE: in_ready=1; on in_valid latch op, dp, tag, A, B, C and go to DEC_A. Output regs unchanged.
//  - DEC_x: dec_fp_in = latched operand x, dec_is_dp = latched dp. The decoder is purely combinational;
//    capture its outputs into slot x at the clock edge that leaves DEC_x.
//  - DEC_B -> DEC_C if op==FMA or SKIP_UNUSED==0, else DONE. For non-FMA ops, C slot sign/exp/mant/class = 0
//    and C is excluded from the flags regardless of SKIP_UNUSED.
//  - Flags are computed from captured classes, registered on DONE entry, and valid with out_valid.
//    ADD invalid: A inf & B inf & signA!=signB. MUL invalid: (A inf & B zero) | (A zero & B inf).
//    FMA invalid: MUL rule | (A or B inf, neither zero, C inf, signA^signB != signC).
//  - DONE: out_valid=1; all out_* hold stable until handshake; in_ready=0 (no overlap).
//  - Latency, accept edge E0: out_valid high after E2 (ADD/MUL, SKIP_UNUSED=1), else after E3.
//    Minimum issue interval: 4 cycles (ADD/MUL) or 5 cycles (FMA).
//  - In IDLE and DONE, dec_fp_in=0. out_valid deasserts the cycle after the handshake.
// TESTING
//  1. ADD FP64 A=0x3FF0000000000000, B=0xC000000000000000 -> out_valid after E2; exp A=0x3FF, B=0x400;
//     mant A=B=1<<52; out_sign=3'b010; C slot 0; flags 0.
//  2. MUL FP32 A=0x7F800000, B=0x00000000 -> out_class A=4'b0010, B=4'b0001; out_invalid=1; out_any_nan=0.
//  3. FMA FP32 A=0x3F800000, B=0x7FC00000, C=0x7F800000 -> valid after E3; out_any_nan=1; out_invalid=0;
//     C class=4'b0010.
//  4. FMA FP64 A=+inf, B=2.0, C=-inf (0xFFF0000000000000) -> out_invalid=1; then hold out_ready=0 for 5 cycles:
//     bundle stable, in_ready=0; release -> IDLE next cycle.
//  5. Assert rst_n=0 during DEC_B of an ADD -> out_valid=0, in_ready=1 after release; next MUL 1.0*1.0 FP32
//     -> exp A=B=0x7F, flags 0.
//  6. SKIP_UNUSED=0, ADD denormal FP32 A=0x00000001 -> valid after E3; mant A=1<<29, class A=4'b1000; C slot 0.

Source files
------------

// File: rtl/fp_operand_sequencer.sv
// rtl/fp_operand_sequencer.sv - steps up to three FP operands through one shared decoder
// and presents the decoded bundle with NaN/invalid flags.
module fp_operand_sequencer #(
  parameter int TAG_W       = 4,
  parameter bit SKIP_UNUSED = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic               in_dp,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [63:0]        in_a,
  input  logic [63:0]        in_b,
  input  logic [63:0]        in_c,
  output logic [63:0]        dec_fp_in,
  output logic               dec_is_dp,
  input  logic               dec_sign,
  input  logic [10:0]        dec_exp,
  input  logic [52:0]        dec_mant,
  input  logic               dec_is_zero,
  input  logic               dec_is_inf,
  input  logic               dec_is_nan,
  input  logic               dec_is_den,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_op,
  output logic               out_dp,
  output logic [TAG_W-1:0]   out_tag,
  output logic [2:0]         out_sign,
  output logic [32:0]        out_exp,
  output logic [158:0]       out_mant,
  output logic [11:0]        out_class,
  output logic               out_any_nan,
  output logic               out_invalid
);

  typedef enum logic [2:0] {S_IDLE, S_DEC_A, S_DEC_B, S_DEC_C, S_DONE} state_t;

  state_t             r_state;
  logic [1:0]         r_op;
  logic               r_dp;
  logic [TAG_W-1:0]   r_tag;
  logic [63:0]        r_a, r_b, r_c;
  logic [63:0]        r_dec_fp_in;
  logic               r_dec_is_dp;

  logic [2:0]         r_s;
  logic [2:0][10:0]   r_e;
  logic [2:0][52:0]   r_m;
  logic [2:0][3:0]    r_cls;

  logic               r_out_valid;
  logic [1:0]         r_out_op;
  logic               r_out_dp;
  logic [TAG_W-1:0]   r_out_tag;
  logic [2:0]         r_out_sign;
  logic [32:0]        r_out_exp;
  logic [158:0]       r_out_mant;
  logic [11:0]        r_out_class;
  logic               r_out_any_nan;
  logic               r_out_invalid;

  logic               w_is_fma, w_is_mul, w_to_c, w_enter_done;
  logic [3:0]         w_dec_cls;
  logic [2:0]         w_s;
  logic [2:0][10:0]   w_e;
  logic [2:0][52:0]   w_m;
  logic [2:0][3:0]    w_c;
  logic               w_any_nan, w_mul_inv, w_add_inv, w_fma_inv, w_inv_raw, w_invalid;

  assign w_is_fma     = (r_op == 2'b10);
  assign w_is_mul     = (r_op == 2'b01);
  assign w_to_c       = w_is_fma || !SKIP_UNUSED;
  assign w_enter_done = ((r_state == S_DEC_B) && !w_to_c) || (r_state == S_DEC_C);
  assign w_dec_cls    = {dec_is_den, dec_is_nan, dec_is_inf, dec_is_zero};

  // Slot view including the decoder result being captured this cycle, so the
  // bundle and flags can be registered on the same edge that enters DONE.
  always_comb begin
    w_s = r_s;
    w_e = r_e;
    w_m = r_m;
    w_c = r_cls;
    case (r_state)
      S_DEC_A: begin w_s[0] = dec_sign; w_e[0] = dec_exp; w_m[0] = dec_mant; w_c[0] = w_dec_cls; end
      S_DEC_B: begin w_s[1] = dec_sign; w_e[1] = dec_exp; w_m[1] = dec_mant; w_c[1] = w_dec_cls; end
      S_DEC_C: begin w_s[2] = dec_sign; w_e[2] = dec_exp; w_m[2] = dec_mant; w_c[2] = w_dec_cls; end
      default: ;
    endcase
    if (!w_is_fma) begin
      w_s[2] = 1'b0;
      w_e[2] = '0;
      w_m[2] = '0;
      w_c[2] = '0;
    end
  end

  // Class bit order per slot is {den,nan,inf,zero}; slot C is already zero for non-FMA.
  always_comb begin
    w_any_nan = w_c[0][2] | w_c[1][2] | w_c[2][2];
    w_mul_inv = (w_c[0][1] & w_c[1][0]) | (w_c[0][0] & w_c[1][1]);
    w_add_inv = w_c[0][1] & w_c[1][1] & (w_s[0] ^ w_s[1]);
    w_fma_inv = w_mul_inv |
                ((w_c[0][1] | w_c[1][1]) & ~w_c[0][0] & ~w_c[1][0] & w_c[2][1] &
                 (w_s[0] ^ w_s[1] ^ w_s[2]));
    if (w_is_fma)      w_inv_raw = w_fma_inv;
    else if (w_is_mul) w_inv_raw = w_mul_inv;
    else               w_inv_raw = w_add_inv;
    w_invalid = w_inv_raw & ~w_any_nan;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_op          <= '0;
      r_dp          <= 1'b0;
      r_tag         <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_c           <= '0;
      r_dec_fp_in   <= '0;
      r_dec_is_dp   <= 1'b0;
      r_s           <= '0;
      r_e           <= '0;
      r_m           <= '0;
      r_cls         <= '0;
      r_out_valid   <= 1'b0;
      r_out_op      <= '0;
      r_out_dp      <= 1'b0;
      r_out_tag     <= '0;
      r_out_sign    <= '0;
      r_out_exp     <= '0;
      r_out_mant    <= '0;
      r_out_class   <= '0;
      r_out_any_nan <= 1'b0;
      r_out_invalid <= 1'b0;
    end else begin
      if (r_state inside {S_DEC_A, S_DEC_B, S_DEC_C}) begin
        r_s   <= w_s;
        r_e   <= w_e;
        r_m   <= w_m;
        r_cls <= w_c;
      end
      if (w_enter_done) begin
        r_out_valid   <= 1'b1;
        r_out_op      <= r_op;
        r_out_dp      <= r_dp;
        r_out_tag     <= r_tag;
        r_out_sign    <= w_s;
        r_out_exp     <= w_e;
        r_out_mant    <= w_m;
        r_out_class   <= w_c;
        r_out_any_nan <= w_any_nan;
        r_out_invalid <= w_invalid;
      end
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op        <= in_op;
            r_dp        <= in_dp;
            r_tag       <= in_tag;
            r_a         <= in_a;
            r_b         <= in_b;
            r_c         <= in_c;
            r_dec_fp_in <= in_a;
            r_dec_is_dp <= in_dp;
            r_state     <= S_DEC_A;
          end
        end
        S_DEC_A: begin
          r_dec_fp_in <= r_b;
          r_state     <= S_DEC_B;
        end
        S_DEC_B: begin
          if (w_to_c) begin
            r_dec_fp_in <= r_c;
            r_state     <= S_DEC_C;
          end else begin
            r_dec_fp_in <= '0;
            r_state     <= S_DONE;
          end
        end
        S_DEC_C: begin
          r_dec_fp_in <= '0;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign dec_fp_in   = r_dec_fp_in;
  assign dec_is_dp   = r_dec_is_dp;
  assign out_valid   = r_out_valid;
  assign out_op      = r_out_op;
  assign out_dp      = r_out_dp;
  assign out_tag     = r_out_tag;
  assign out_sign    = r_out_sign;
  assign out_exp     = r_out_exp;
  assign out_mant    = r_out_mant;
  assign out_class   = r_out_class;
  assign out_any_nan = r_out_any_nan;
  assign out_invalid = r_out_invalid;

endmodule

// File: tb/tb_fp_operand_sequencer.sv
// tb/tb_fp_operand_sequencer.sv - scoreboard bench with a behavioural FP decoder
// feeding both a skipping and a fixed-latency sequencer instance.
module tb_fp_operand_sequencer;

  typedef struct packed {
    logic [1:0]   op;
    logic         dp;
    logic [3:0]   tag;
    logic [2:0]   sign;
    logic [32:0]  ex;
    logic [158:0] mant;
    logic [11:0]  cls;
    logic         any_nan;
    logic         invalid;
  } bundle_t;

  typedef struct {
    bundle_t b;
    int      lat;
    int      e0;
  } exp_t;

  localparam logic [52:0] M1 = 53'h10000000000000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  exp_t sb_q[$];

  // Main instance (SKIP_UNUSED=1)
  logic in_valid, in_ready, in_dp, out_valid, out_ready, out_dp, out_any_nan, out_invalid;
  logic [1:0] in_op, out_op;
  logic [3:0] in_tag, out_tag;
  logic [63:0] in_a, in_b, in_c, dec_fp_in;
  logic dec_is_dp, dec_sign, dec_is_zero, dec_is_inf, dec_is_nan, dec_is_den;
  logic [10:0] dec_exp;
  logic [52:0] dec_mant;
  logic [2:0] out_sign;
  logic [32:0] out_exp;
  logic [158:0] out_mant;
  logic [11:0] out_class;

  // Fixed-latency instance (SKIP_UNUSED=0)
  logic n_in_valid, n_in_ready, n_in_dp, n_out_valid, n_out_ready, n_out_dp, n_out_any_nan, n_out_invalid;
  logic [1:0] n_in_op, n_out_op;
  logic [3:0] n_in_tag, n_out_tag;
  logic [63:0] n_in_a, n_in_b, n_in_c, n_dec_fp_in;
  logic n_dec_is_dp, n_dec_sign, n_dec_is_zero, n_dec_is_inf, n_dec_is_nan, n_dec_is_den;
  logic [10:0] n_dec_exp;
  logic [52:0] n_dec_mant;
  logic [2:0] n_out_sign;
  logic [32:0] n_out_exp;
  logic [158:0] n_out_mant;
  logic [11:0] n_out_class;

  function automatic logic [68:0] decode(input logic [63:0] x, input logic dp);
    logic s;
    logic [10:0] e, emax;
    logic [51:0] f;
    logic [3:0] c;
    if (dp) begin
      s = x[63]; e = x[62:52]; f = x[51:0]; emax = 11'h7FF;
    end else begin
      s = x[31]; e = {3'b000, x[30:23]}; f = {x[22:0], 29'b0}; emax = 11'h0FF;
    end
    c = {(e == 11'h0) && (f != 52'h0), (e == emax) && (f != 52'h0),
         (e == emax) && (f == 52'h0), (e == 11'h0) && (f == 52'h0)};
    return {s, e, (e != 11'h0), f, c};
  endfunction

  assign {dec_sign, dec_exp, dec_mant, dec_is_den, dec_is_nan, dec_is_inf, dec_is_zero} =
         decode(dec_fp_in, dec_is_dp);
  assign {n_dec_sign, n_dec_exp, n_dec_mant, n_dec_is_den, n_dec_is_nan, n_dec_is_inf, n_dec_is_zero} =
         decode(n_dec_fp_in, n_dec_is_dp);

  fp_operand_sequencer #(.TAG_W(4), .SKIP_UNUSED(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_dp(in_dp), .in_tag(in_tag), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .dec_fp_in(dec_fp_in), .dec_is_dp(dec_is_dp), .dec_sign(dec_sign), .dec_exp(dec_exp),
    .dec_mant(dec_mant), .dec_is_zero(dec_is_zero), .dec_is_inf(dec_is_inf),
    .dec_is_nan(dec_is_nan), .dec_is_den(dec_is_den), .out_valid(out_valid),
    .out_ready(out_ready), .out_op(out_op), .out_dp(out_dp), .out_tag(out_tag),
    .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant), .out_class(out_class),
    .out_any_nan(out_any_nan), .out_invalid(out_invalid));

  fp_operand_sequencer #(.TAG_W(4), .SKIP_UNUSED(1'b0)) u_dut_ns (
    .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready), .in_op(n_in_op),
    .in_dp(n_in_dp), .in_tag(n_in_tag), .in_a(n_in_a), .in_b(n_in_b), .in_c(n_in_c),
    .dec_fp_in(n_dec_fp_in), .dec_is_dp(n_dec_is_dp), .dec_sign(n_dec_sign), .dec_exp(n_dec_exp),
    .dec_mant(n_dec_mant), .dec_is_zero(n_dec_is_zero), .dec_is_inf(n_dec_is_inf),
    .dec_is_nan(n_dec_is_nan), .dec_is_den(n_dec_is_den), .out_valid(n_out_valid),
    .out_ready(n_out_ready), .out_op(n_out_op), .out_dp(n_out_dp), .out_tag(n_out_tag),
    .out_sign(n_out_sign), .out_exp(n_out_exp), .out_mant(n_out_mant), .out_class(n_out_class),
    .out_any_nan(n_out_any_nan), .out_invalid(n_out_invalid));

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic check_bundle(input string tn, input bundle_t a, input bundle_t e);
    chk({tn, ".op"},      256'(a.op),      256'(e.op));
    chk({tn, ".dp"},      256'(a.dp),      256'(e.dp));
    chk({tn, ".tag"},     256'(a.tag),     256'(e.tag));
    chk({tn, ".sign"},    256'(a.sign),    256'(e.sign));
    chk({tn, ".exp"},     256'(a.ex),      256'(e.ex));
    chk({tn, ".mant"},    256'(a.mant),    256'(e.mant));
    chk({tn, ".class"},   256'(a.cls),     256'(e.cls));
    chk({tn, ".any_nan"}, 256'(a.any_nan), 256'(e.any_nan));
    chk({tn, ".invalid"}, 256'(a.invalid), 256'(e.invalid));
  endtask

  function automatic bundle_t mk_b(input logic [1:0] op, input logic dp, input logic [3:0] tag,
                                   input logic [2:0] sign, input logic [32:0] ex,
                                   input logic [158:0] mant, input logic [11:0] cls,
                                   input logic nan, input logic inv);
    bundle_t b;
    b.op = op; b.dp = dp; b.tag = tag; b.sign = sign; b.ex = ex;
    b.mant = mant; b.cls = cls; b.any_nan = nan; b.invalid = inv;
    return b;
  endfunction

  // Monitor: first sight of a bundle pops and compares; later cycles check it holds.
  initial begin
    bundle_t cur, snap;
    exp_t e;
    bit seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1 || out_valid !== 1'b1) begin
        seen = 1'b0;
      end else begin
        cur = {out_op, out_dp, out_tag, out_sign, out_exp, out_mant, out_class, out_any_nan, out_invalid};
        if (!seen) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_bundle", 256'(cur.tag), 256'hDEAD);
          end else begin
            e = sb_q.pop_front();
            check_bundle($sformatf("tag%0d", e.b.tag), cur, e.b);
            chk($sformatf("tag%0d.latency", e.b.tag), 256'(cyc - e.e0), 256'(e.lat));
          end
          snap = cur;
          seen = 1'b1;
        end else begin
          chk("bundle_stable", 256'(cur), 256'(snap));
        end
        chk("in_ready_in_done", 256'(in_ready), 256'(0));
        if (out_ready) seen = 1'b0;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic dp, input logic [3:0] tag,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input bit push, input bundle_t eb, input int lat);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("issue_timeout", 256'(0), 256'(1));
      return;
    end
    in_valid = 1'b1; in_op = op; in_dp = dp; in_tag = tag; in_a = a; in_b = b; in_c = c;
    @(posedge clk);
    #1;
    if (push) sb_q.push_back('{b: eb, lat: lat, e0: cyc});
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !out_valid && in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("drain_timeout", 256'(sb_q.size()), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bundle_t nb, eb;
    int e0, lat;
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_dp = 1'b0; in_tag = '0;
    in_a = '0; in_b = '0; in_c = '0; out_ready = 1'b1;
    n_in_valid = 1'b0; n_in_op = '0; n_in_dp = 1'b0; n_in_tag = '0;
    n_in_a = '0; n_in_b = '0; n_in_c = '0; n_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.out_valid", 256'(out_valid), 256'(0));
    chk("rst.dec_fp_in", 256'(dec_fp_in), 256'(0));
    chk("rst.dec_is_dp", 256'(dec_is_dp), 256'(0));
    chk("rst.bundle", 256'({out_sign, out_exp, out_mant, out_class, out_any_nan, out_invalid}), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.in_ready", 256'(in_ready), 256'(1));

    issue(2'b00, 1'b1, 4'h1, 64'h3FF0000000000000, 64'hC000000000000000, 64'h4008000000000000, 1'b1,
          mk_b(2'b00, 1'b1, 4'h1, 3'b010, {11'h000, 11'h400, 11'h3FF}, {53'h0, M1, M1}, 12'h000, 1'b0, 1'b0), 2);
    drain();
    issue(2'b01, 1'b0, 4'h2, 64'h7F800000, 64'h00000000, 64'h3F800000, 1'b1,
          mk_b(2'b01, 1'b0, 4'h2, 3'b000, {11'h000, 11'h000, 11'h0FF}, {53'h0, 53'h0, M1}, 12'h012, 1'b0, 1'b1), 2);
    drain();
    issue(2'b11, 1'b0, 4'h3, 64'h7F800000, 64'hFF800000, 64'h7FC00000, 1'b1,
          mk_b(2'b11, 1'b0, 4'h3, 3'b010, {11'h000, 11'h0FF, 11'h0FF}, {53'h0, M1, M1}, 12'h022, 1'b0, 1'b1), 2);
    drain();
    issue(2'b10, 1'b0, 4'h4, 64'h3F800000, 64'h7FC00000, 64'h7F800000, 1'b1,
          mk_b(2'b10, 1'b0, 4'h4, 3'b000, {11'h0FF, 11'h0FF, 11'h07F},
               {M1, 53'h18000000000000, M1}, 12'h240, 1'b1, 1'b0), 3);
    drain();

    // Back-pressure: bundle must hold while out_ready is low
    out_ready = 1'b0;
    issue(2'b10, 1'b1, 4'h5, 64'h7FF0000000000000, 64'h4000000000000000, 64'hFFF0000000000000, 1'b1,
          mk_b(2'b10, 1'b1, 4'h5, 3'b100, {11'h7FF, 11'h400, 11'h7FF}, {M1, M1, M1}, 12'h202, 1'b0, 1'b1), 3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("release.out_valid", 256'(out_valid), 256'(0));
    chk("release.in_ready", 256'(in_ready), 256'(1));

    // Reset while the ADD is in DEC_B
    issue(2'b00, 1'b0, 4'h9, 64'h3F800000, 64'h3F800000, 64'h0, 1'b0, '0, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 256'(out_valid), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst.in_ready", 256'(in_ready), 256'(1));
    chk("midrst.dec_fp_in", 256'(dec_fp_in), 256'(0));
    repeat (4) @(negedge clk);
    chk("midrst.no_bundle", 256'(out_valid), 256'(0));
    issue(2'b01, 1'b0, 4'h6, 64'h3F800000, 64'h3F800000, 64'h0, 1'b1,
          mk_b(2'b01, 1'b0, 4'h6, 3'b000, {11'h000, 11'h07F, 11'h07F}, {53'h0, M1, M1}, 12'h000, 1'b0, 1'b0), 2);
    drain();

    // Fixed-latency instance: C decoded but masked for ADD
    @(negedge clk);
    n_in_valid = 1'b1; n_in_op = 2'b00; n_in_dp = 1'b0; n_in_tag = 4'h7;
    n_in_a = 64'h00000001; n_in_b = 64'h3F800000; n_in_c = 64'h7FC00000;
    chk("ns.in_ready", 256'(n_in_ready), 256'(1));
    @(posedge clk);
    #1;
    e0 = cyc;
    n_in_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (n_out_valid) begin lat = cyc - e0; break; end
    end
    chk("ns.latency", 256'(lat), 256'(3));
    nb = {n_out_op, n_out_dp, n_out_tag, n_out_sign, n_out_exp, n_out_mant, n_out_class,
          n_out_any_nan, n_out_invalid};
    eb = mk_b(2'b00, 1'b0, 4'h7, 3'b000, {11'h000, 11'h07F, 11'h000},
              {53'h0, M1, 53'h00000020000000}, 12'h008, 1'b0, 1'b0);
    check_bundle("ns", nb, eb);
    @(negedge clk);
    chk("ns.out_valid_clear", 256'(n_out_valid), 256'(0));

    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
